// File: rtl/controle_painel.sv
// Scrolling-panel controller: debounced-edge buttons, tick divider, mode FSM driving {ch1,ch0}.
// Define CONTROLE_PAINEL_BOUNCE_EN for ping-pong scrolling instead of wrap-around.
module controle_painel #(
  parameter int DIV  = 4,
  parameter int COLS = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       btn_modo,
  input  logic       btn_pausa,
  output logic       ch0,
  output logic       ch1,
  output logic [7:0] pos,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN_RL = 3'd2,
    RUN_LR = 3'd3,
    PAUSE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_RL, DIR_LR} dir_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [7:0]  POS_LAST = 8'(COLS - 1);

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [1:0]  modo_sync_q, modo_sync_d, pausa_sync_q, pausa_sync_d;
  logic        modo_prev_q, modo_prev_d, pausa_prev_q, pausa_prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pos_q, pos_d;
  logic        up_q, up_d;
  logic [1:0]  ch_q, ch_d;
  logic        modo_edge, pausa_edge, run, run_d, tick, tick_d, flip_d;

  always_comb begin
    modo_sync_d  = {modo_sync_q[0], btn_modo};
    pausa_sync_d = {pausa_sync_q[0], btn_pausa};
    modo_prev_d  = modo_sync_q[1];
    pausa_prev_d = pausa_sync_q[1];
    modo_edge    = modo_sync_q[1] & ~modo_prev_q;
    pausa_edge   = pausa_sync_q[1] & ~pausa_prev_q;
    run          = (state_q == RUN_RL) || (state_q == RUN_LR);
    tick         = run && (cnt_q == DIV_LAST);

    state_d = state_q;
    pos_d   = pos_q;
    up_d    = up_q;
    dir_d   = dir_q;

    case (state_q)
      IDLE: if (modo_edge) state_d = LOAD;
      LOAD: state_d = (dir_q == DIR_RL) ? RUN_LR : RUN_RL;
      RUN_RL, RUN_LR: begin
        if (modo_edge) state_d = LOAD;
        else if (pausa_edge) state_d = PAUSE;
        else if (tick) begin
`ifdef CONTROLE_PAINEL_BOUNCE_EN
          if (up_q ? (pos_q == POS_LAST) : (pos_q == 8'd0)) begin
            state_d = (state_q == RUN_RL) ? RUN_LR : RUN_RL;
            up_d    = ~up_q;
            pos_d   = up_q ? pos_q - 8'd1 : pos_q + 8'd1;
          end else begin
            pos_d = up_q ? pos_q + 8'd1 : pos_q - 8'd1;
          end
`else
          pos_d = (pos_q == POS_LAST) ? 8'd0 : pos_q + 8'd1;
`endif
        end
      end
      PAUSE: begin
        if (modo_edge) state_d = LOAD;
        else if (pausa_edge) state_d = (dir_q == DIR_LR) ? RUN_LR : RUN_RL;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == LOAD) begin
      pos_d = 8'd0;
      up_d  = 1'b1;
    end
    if (state_d == RUN_RL) dir_d = DIR_RL;
    if (state_d == RUN_LR) dir_d = DIR_LR;

    // Counter restarts whenever a run is entered from LOAD or PAUSE.
    run_d  = (state_d == RUN_RL) || (state_d == RUN_LR);
    cnt_d  = (run && run_d) ? ((cnt_q == DIV_LAST) ? 16'd0 : cnt_q + 16'd1) : 16'd0;
    tick_d = run_d && (cnt_d == DIV_LAST);

    // Registered outputs look ahead one cycle; an end-of-scroll tick already shows the new direction.
`ifdef CONTROLE_PAINEL_BOUNCE_EN
    flip_d = up_d ? (pos_d == POS_LAST) : (pos_d == 8'd0);
`else
    flip_d = 1'b0;
`endif
    ch_d = 2'b11;
    case (state_d)
      LOAD:    ch_d = 2'b00;
      RUN_RL:  if (tick_d) ch_d = flip_d ? 2'b10 : 2'b01;
      RUN_LR:  if (tick_d) ch_d = flip_d ? 2'b01 : 2'b10;
      default: ch_d = 2'b11;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      dir_q        <= DIR_NONE;
      modo_sync_q  <= 2'b00;
      pausa_sync_q <= 2'b00;
      modo_prev_q  <= 1'b0;
      pausa_prev_q <= 1'b0;
      cnt_q        <= 16'd0;
      pos_q        <= 8'd0;
      up_q         <= 1'b1;
      ch_q         <= 2'b11;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      modo_sync_q  <= modo_sync_d;
      pausa_sync_q <= pausa_sync_d;
      modo_prev_q  <= modo_prev_d;
      pausa_prev_q <= pausa_prev_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      up_q         <= up_d;
      ch_q         <= ch_d;
    end
  end

  assign ch0    = ch_q[0];
  assign ch1    = ch_q[1];
  assign pos    = pos_q;
  assign estado = state_q;

endmodule

// File: tb/tb_controle_painel.sv
// Self-checking bench for controle_painel: vector table for start-up, then directed multi-cycle sequences.
module tb_controle_painel;
  localparam int DIV  = 4;
  localparam int COLS = 8;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       btn_modo = 1'b0;
  logic       btn_pausa = 1'b0;
  logic       ch0, ch1;
  logic [7:0] pos;
  logic [2:0] estado;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the observable state, advanced one clock at a time.
  int m_state, m_pos, m_cnt, m_dir;
  bit m_up;

  typedef struct {
    logic       modo;
    logic       pausa;
    logic [1:0] ch;
    logic [2:0] est;
    logic [7:0] pos;
  } vec_t;
  vec_t vecs[12];

  controle_painel #(.DIV(DIV), .COLS(COLS)) dut (
    .CLK(CLK), .RSTn(RSTn), .btn_modo(btn_modo), .btn_pausa(btn_pausa),
    .ch0(ch0), .ch1(ch1), .pos(pos), .estado(estado)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [12:0] got, input logic [12:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got ch=%b estado=%0d pos=%0d, want ch=%b estado=%0d pos=%0d",
               name, got[12:11], got[10:8], got[7:0], want[12:11], want[10:8], want[7:0]);
    end
  endtask

  function automatic logic [1:0] exp_ch();
    bit rl;
    if (m_state == 1) return 2'b00;
    if ((m_state == 2 || m_state == 3) && m_cnt == DIV - 1) begin
      rl = (m_state == 2);
`ifdef CONTROLE_PAINEL_BOUNCE_EN
      if (m_up ? (m_pos == COLS - 1) : (m_pos == 0)) rl = !rl;
`endif
      return rl ? 2'b01 : 2'b10;
    end
    return 2'b11;
  endfunction

  task automatic model_advance();
    if (m_state == 1) begin
      m_state = (m_dir == 1) ? 3 : 2;
      m_dir   = m_state - 1;
      m_cnt   = 0;
    end else if (m_state == 2 || m_state == 3) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
`ifdef CONTROLE_PAINEL_BOUNCE_EN
        if (m_up ? (m_pos == COLS - 1) : (m_pos == 0)) begin
          m_state = (m_state == 2) ? 3 : 2;
          m_dir   = m_state - 1;
          m_pos   = m_up ? m_pos - 1 : m_pos + 1;
          m_up    = !m_up;
        end else begin
          m_pos = m_up ? m_pos + 1 : m_pos - 1;
        end
`else
        m_pos = (m_pos + 1) % COLS;
`endif
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step_check(input string name);
    @(posedge CLK);
    #1;
    check_output(name, {ch1, ch0, estado, pos}, {exp_ch(), 3'(m_state), 8'(m_pos)});
  endtask

  task automatic run_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      model_advance();
      step_check(name);
    end
  endtask

  // Hold the pins high for two edges; the action lands on the third edge.
  task automatic apply_stimulus(input bit m, input bit p, input string name);
    btn_modo  = m;
    btn_pausa = p;
    run_cycles(2, name);
    btn_modo  = 1'b0;
    btn_pausa = 1'b0;
    if (m) begin
      m_state = 1; m_pos = 0; m_up = 1'b1; m_cnt = 0;
    end else if (p) begin
      if (m_state == 4) m_state = (m_dir == 2) ? 3 : 2;
      else m_state = 4;
      m_cnt = 0;
    end
    step_check(name);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 3'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b11, 3'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 3'd1, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 3'd2, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 3'd2, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 3'd2, 8'd2};

    #12;
    check_output("reset_state", {ch1, ch0, estado, pos}, {2'b11, 3'd0, 8'd0});
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      btn_modo  = vecs[i].modo;
      btn_pausa = vecs[i].pausa;
      @(posedge CLK);
      #1;
      check_output($sformatf("vec%0d", i), {ch1, ch0, estado, pos},
                   {vecs[i].ch, vecs[i].est, vecs[i].pos});
    end
    btn_modo = 1'b0;

    m_state = 2; m_pos = 2; m_cnt = 0; m_dir = 1; m_up = 1'b1;
    run_cycles(4, "run_to_pos3");

    apply_stimulus(1'b0, 1'b1, "pause_enter");
    check_output("pause_hand", {ch1, ch0, estado, pos}, {2'b11, 3'd4, 8'd3});
    run_cycles(50, "pause_hold");

    apply_stimulus(1'b0, 1'b1, "pause_resume");
    run_cycles(2, "resume_wait");
    model_advance();
    step_check("resume_tick");
    check_output("resume_tick_hand", {ch1, ch0, estado, pos}, {2'b01, 3'd2, 8'd3});
    run_cycles(1, "resume_after");

    apply_stimulus(1'b1, 1'b0, "modo_to_load");
    check_output("load_hand", {ch1, ch0, estado, pos}, {2'b00, 3'd1, 8'd0});
    run_cycles(4, "run_lr_first");
    check_output("run_lr_tick_hand", {ch1, ch0, estado, pos}, {2'b10, 3'd3, 8'd0});
    run_cycles(5, "run_lr");

    apply_stimulus(1'b1, 1'b1, "both_buttons");
    check_output("both_hand", {ch1, ch0, estado, pos}, {2'b00, 3'd1, 8'd0});
    run_cycles(1, "both_next");
    check_output("both_run_rl", {ch1, ch0, estado}, {2'b11, 3'd2});

    run_cycles(DIV * COLS, "scroll_pass");
`ifdef CONTROLE_PAINEL_BOUNCE_EN
    check_output("scroll_end_hand", {ch1, ch0, estado, pos}, {2'b11, 3'd3, 8'd6});
`else
    check_output("scroll_end_hand", {ch1, ch0, estado, pos}, {2'b11, 3'd2, 8'd0});
`endif

    apply_stimulus(1'b1, 1'b0, "modo_again");
    run_cycles(1 + 2 * DIV + (DIV - 1), "to_tick_pos2");
`ifndef CONTROLE_PAINEL_BOUNCE_EN
    check_output("lr_tick_hand", {ch1, ch0, estado, pos}, {2'b10, 3'd3, 8'd2});
`endif
    #2;
    RSTn = 1'b0;
    #1;
    check_output("reset_async", {ch1, ch0, estado, pos}, {2'b11, 3'd0, 8'd0});
    m_state = 0; m_pos = 0; m_cnt = 0; m_dir = 0; m_up = 1'b1;
    step_check("reset_hold");
    step_check("reset_hold");
    @(negedge CLK);
    RSTn = 1'b1;
    step_check("after_release");
    step_check("idle_stays");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
